// File: rtl/gate_sweep_if.sv
// Connection bundle between the sweep checker, its controller and the
// two-input gate unit under test.
//
// Handshake: the controller raises start for at least one cycle while busy
// is low; the checker accepts it only when idle, holds busy high for the
// whole sweep, then drops busy and pulses done for exactly one cycle.
// start is neither queued nor acknowledged while a sweep is running.
// Results (pass, err_count, fail_vec, fail_mask) hold from the done
// cycle until the next accepted start.
interface gate_sweep_if #(
    parameter int ERRW = 8
);
    logic            start;
    logic            a;
    logic            b;
    logic            x_and;
    logic            x_or;
    logic            x_xor;
    logic            x_not;
    logic            x_xnor;
    logic            x_nand;
    logic            x_nor;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_count;
    logic [1:0]      fail_vec;
    logic [6:0]      fail_mask;
    logic [1:0]      dbg_state;

    modport master (
        output start, x_and, x_or, x_xor, x_not, x_xnor, x_nand, x_nor,
        input  a, b, busy, done, pass, err_count, fail_vec, fail_mask, dbg_state
    );

    modport slave (
        input  start, x_and, x_or, x_xor, x_not, x_xnor, x_nand, x_nor,
        output a, b, busy, done, pass, err_count, fail_vec, fail_mask, dbg_state
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Drives the gate unit through all four {a,b} vectors, samples its seven
// outputs after SETTLE cycles per vector and checks them against the
// expected truth table. Reports mismatch count, pass and first failure.
module gate_sweep_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_sweep_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]      TC   = 4'(SETTLE - 1);
    localparam logic [ERRW+2:0] MAXV = {3'b000, {ERRW{1'b1}}};

    state_t          state;
    logic [3:0]      cnt;
    logic [1:0]      v;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [ERRW-1:0] err_r;
    logic [1:0]      fvec_r;
    logic [6:0]      fmask_r;

    logic [6:0]      obs;
    logic [6:0]      expv;
    logic [6:0]      mism;
    logic [2:0]      pc;
    logic [ERRW+2:0] sum;
    logic [ERRW-1:0] err_next;

    // Compare the sampled responses against the truth table for vector v
    // and form the saturated running mismatch count.
    always_comb begin
        obs  = {bus.x_nor, bus.x_nand, bus.x_xnor, bus.x_not,
                bus.x_xor, bus.x_or, bus.x_and};
        expv = {~(v[1] | v[0]), ~(v[1] & v[0]), ~(v[1] ^ v[0]), ~v[1],
                v[1] ^ v[0], v[1] | v[0], v[1] & v[0]};
        mism = obs ^ expv;
        pc   = 3'd0;
        for (int i = 0; i < 7; i++) begin
            pc = pc + {2'b00, mism[i]};
        end
        sum      = {3'b000, err_r} + {{ERRW{1'b0}}, pc};
        err_next = (sum > MAXV) ? {ERRW{1'b1}} : sum[ERRW-1:0];
    end

    // Sweep FSM: accept start, step through vectors, latch results.
    // An all-zero fail_mask means no failing vector has been seen yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            v       <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= '0;
            fvec_r  <= 2'd0;
            fmask_r <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state   <= RUN;
                        busy_r  <= 1'b1;
                        cnt     <= 4'd0;
                        v       <= 2'd0;
                        pass_r  <= 1'b0;
                        err_r   <= '0;
                        fvec_r  <= 2'd0;
                        fmask_r <= 7'd0;
                    end
                end
                RUN: begin
                    if (cnt == TC) begin
                        err_r <= err_next;
                        if (mism != 7'd0 && fmask_r == 7'd0) begin
                            fvec_r  <= v;
                            fmask_r <= mism;
                        end
                        if (v != 2'd3) begin
                            v   <= v + 2'd1;
                            cnt <= 4'd0;
                        end else begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (err_next == '0);
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    cnt    <= 4'd0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a         = v[1];
    assign bus.b         = v[0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fvec_r;
    assign bus.fail_mask = fmask_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a wide-counter instance (SETTLE=2, ERRW=8)
// and a narrow saturating one (SETTLE=3, ERRW=4) share a fault-injectable
// gate model. Table entries and random faults are swept; every cycle of
// a sweep is checked for a/b, busy and done, then the reported results.
module tb_gate_sweep_checker;
    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic       sel;
    logic [6:0] inv_m [4];
    logic [6:0] s1;
    logic [6:0] s0;

    gate_sweep_if #(.ERRW(8)) bus0 ();
    gate_sweep_if #(.ERRW(4)) bus1 ();

    gate_sweep_checker #(.SETTLE(2), .ERRW(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate_sweep_checker #(.SETTLE(3), .ERRW(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference truth table from plain arithmetic on 0/1 values.
    function automatic logic [6:0] exp7(input int a, input int b);
        logic [6:0] r;
        r[0] = (a * b) != 0;
        r[1] = (a + b) != 0;
        r[2] = ((a + b) % 2) != 0;
        r[3] = (a == 0);
        r[4] = ((a + b) % 2) == 0;
        r[5] = (a * b) == 0;
        r[6] = (a + b) == 0;
        return r;
    endfunction

    // Gate unit model with injectable faults (per-vector inversion, stuck-at).
    assign {bus0.x_nor, bus0.x_nand, bus0.x_xnor, bus0.x_not, bus0.x_xor, bus0.x_or, bus0.x_and} =
        ((exp7(int'(bus0.a), int'(bus0.b)) ^ inv_m[{bus0.a, bus0.b}]) | s1) & ~s0;
    assign {bus1.x_nor, bus1.x_nand, bus1.x_xnor, bus1.x_not, bus1.x_xor, bus1.x_or, bus1.x_and} =
        ((exp7(int'(bus1.a), int'(bus1.b)) ^ inv_m[{bus1.a, bus1.b}]) | s1) & ~s0;

    // Muxed view of the selected instance.
    logic [1:0] m_ab;
    logic       m_busy, m_done, m_pass;
    logic [7:0] m_err;
    logic [1:0] m_vec;
    logic [6:0] m_mask;
    assign m_ab   = sel ? {bus1.a, bus1.b} : {bus0.a, bus0.b};
    assign m_busy = sel ? bus1.busy : bus0.busy;
    assign m_done = sel ? bus1.done : bus0.done;
    assign m_pass = sel ? bus1.pass : bus0.pass;
    assign m_err  = sel ? {4'b0000, bus1.err_count} : bus0.err_count;
    assign m_vec  = sel ? bus1.fail_vec : bus0.fail_vec;
    assign m_mask = sel ? bus1.fail_mask : bus0.fail_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input logic val);
        if (sel) bus1.start = val;
        else     bus0.start = val;
    endtask

    task automatic set_faults(input logic [6:0] inv, input logic [6:0] f1, input logic [6:0] f0);
        for (int i = 0; i < 4; i++) inv_m[i] = inv;
        s1 = f1;
        s0 = f0;
    endtask

    // Behavioural prediction of the sweep result from the current faults.
    task automatic predict(input logic s, output logic [7:0] e_err, output logic [1:0] e_vec,
                           output logic [6:0] e_mask, output logic e_pass);
        int total = 0;
        int maxv  = s ? 15 : 255;
        logic found = 1'b0;
        e_vec  = 2'd0;
        e_mask = 7'd0;
        for (int v = 0; v < 4; v++) begin
            logic [6:0] e;
            logic [6:0] o;
            e = exp7(v / 2, v % 2);
            o = ((e ^ inv_m[v]) | s1) & ~s0;
            total += $countones(o ^ e);
            if (!found && (o ^ e) != 7'd0) begin
                found  = 1'b1;
                e_vec  = 2'(v);
                e_mask = o ^ e;
            end
        end
        if (total > maxv) total = maxv;
        e_err  = 8'(total);
        e_pass = (total == 0);
    endtask

    // One full sweep checked cycle by cycle; poke adds ignored start pulses.
    task automatic sweep(input logic s, input logic [7:0] e_err, input logic [1:0] e_vec,
                         input logic [6:0] e_mask, input logic e_pass, input logic poke);
        int st;
        sel = s;
        st  = s ? 3 : 2;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int t = 0; t <= 4 * st + 1; t++) begin
            if (t > 0) @(negedge clk);
            if (poke && (t == 4 || t == 4 * st + 1)) set_start(1'b0);
            if (t < 4 * st) begin
                check("ab", 32'(m_ab), 32'(t / st));
                check("busy_run", 32'(m_busy), 32'd1);
                check("done_run", 32'(m_done), 32'd0);
            end else if (t == 4 * st) begin
                check("ab_end", 32'(m_ab), 32'd3);
                check("done_pulse", 32'(m_done), 32'd1);
                check("busy_end", 32'(m_busy), 32'd0);
                check("err_count", 32'(m_err), 32'(e_err));
                check("fail_vec", 32'(m_vec), 32'(e_vec));
                check("fail_mask", 32'(m_mask), 32'(e_mask));
                check("pass", 32'(m_pass), 32'(e_pass));
            end else begin
                check("done_clear", 32'(m_done), 32'd0);
                check("busy_idle", 32'(m_busy), 32'd0);
                check("ab_hold", 32'(m_ab), 32'd3);
                check("pass_hold", 32'(m_pass), 32'(e_pass));
                check("err_hold", 32'(m_err), 32'(e_err));
            end
            if (poke && (t == 3 || t == 4 * st)) set_start(1'b1);
        end
        @(negedge clk);
        check("no_restart", 32'(m_busy), 32'd0);
    endtask

    typedef struct {
        logic       s;
        logic [6:0] inv;
        logic [6:0] f1;
        logic [6:0] f0;
        logic [7:0] e_err;
        logic [1:0] e_vec;
        logic [6:0] e_mask;
        logic       e_pass;
        logic       poke;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] p_err;
        logic [1:0] p_vec;
        logic [6:0] p_mask;
        logic       p_pass;

        tbl[0] = '{1'b0, 7'h00, 7'h00, 7'h00, 8'd0,  2'd0, 7'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 7'h00, 7'h00, 7'h01, 8'd1,  2'd3, 7'h01, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 7'h00, 7'h08, 7'h00, 8'd2,  2'd2, 7'h08, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 7'h7F, 7'h00, 7'h00, 8'd15, 2'd0, 7'h7F, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 7'h00, 7'h00, 7'h00, 8'd0,  2'd0, 7'h00, 1'b1, 1'b1};

        sel = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        set_faults(7'h00, 7'h00, 7'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ab", 32'(m_ab), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_pass", 32'(m_pass), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_vec", 32'(m_vec), 32'd0);
        check("rst_mask", 32'(m_mask), 32'd0);

        // Table-driven sweeps
        for (int i = 0; i < 5; i++) begin
            set_faults(tbl[i].inv, tbl[i].f1, tbl[i].f0);
            sweep(tbl[i].s, tbl[i].e_err, tbl[i].e_vec, tbl[i].e_mask, tbl[i].e_pass, tbl[i].poke);
        end

        // Asynchronous reset during vector 1, then a clean sweep
        set_faults(7'h00, 7'h00, 7'h00);
        sel = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (2) @(negedge clk);
        check("pre_rst_ab", 32'(m_ab), 32'd1);
        check("pre_rst_busy", 32'(m_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ab", 32'(m_ab), 32'd0);
        check("arst_busy", 32'(m_busy), 32'd0);
        check("arst_done", 32'(m_done), 32'd0);
        check("arst_err", 32'(m_err), 32'd0);
        check("arst_mask", 32'(m_mask), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(m_done), 32'd0);
        end
        rst_n = 1'b1;
        sweep(1'b0, 8'd0, 2'd0, 7'h00, 1'b1, 1'b0);

        // Randomized faults against the behavioural model
        for (int n = 0; n < 10; n++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            for (int v = 0; v < 4; v++) inv_m[v] = 7'($urandom) & 7'($urandom);
            s1 = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
            s0 = 7'h00;
            predict(s, p_err, p_vec, p_mask, p_pass);
            sweep(s, p_err, p_vec, p_mask, p_pass, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response engine for the two-input basic-gate unit (and, or, xor, not, xnor, nand, nor). On command it drives the unit's `a`/`b` inputs through all four input combinations. After a programmable settle time it samples the seven gate outputs and compares them against the expected truth table. It reports the mismatch count, pass/fail status and first-failure details, replacing the hand-checked monitor printout with hardware checking usable in simulation and on silicon.

## Interface
Parameters:
- `SETTLE`, default 2: cycles between driving a vector and sampling outputs; legal range 1..15.
- `ERRW`, default 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `a`, `b`  out  1 each  stimulus to the gate unit.
- `x_and`, `x_or`, `x_xor`, `x_not`, `x_xnor`, `x_nand`, `x_nor`  in  1 each  gate-unit responses.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  high when the last sweep had zero mismatches.
- `err_count`  out  ERRW  total mismatched output bits in the last sweep; saturating.
- `fail_vec`  out  2  index {a,b} of the first vector with any mismatch.
- `fail_mask`  out  7  mismatch bits of that first failing vector.

## Operation
- Mask bit order: 0 and, 1 or, 2 xor, 3 not, 4 xnor, 5 nand, 6 nor.
- Expected values: and=a&b, or=a|b, xor=a^b, not=~a, xnor=~(a^b), nand=~(a&b), nor=~(a|b).
- Vector index v (2 bits) maps to a=v[1], b=v[0]. Sweep order: 0, 1, 2, 3.
- FSM states:
  - IDLE -> RUN on `start`.
  - RUN (settle counter 0..SETTLE-1, vector v): on each counter terminal count, compare inputs; if v<3, v++ and counter clears; if v==3 -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- On accepting `start`:
  - clear `err_count`, `fail_vec`, `fail_mask` and `pass`.
  - load v=0, so a=0, b=0.
- At each sample:
  - mismatch = observed XOR expected (7 bits).
  - `err_count` += popcount(mismatch), saturating at 2^ERRW-1.
  - If this is the first nonzero mismatch of the sweep, latch v into `fail_vec` and mismatch into `fail_mask`.
- `pass` is set in DONE iff the final `err_count` is 0. It is held, along with `err_count`, `fail_vec` and `fail_mask`, until the next accepted `start`.
- `a`/`b` hold vector 3 after the sweep and until the next `start`.
- `start` in RUN or DONE is ignored; it is not queued.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_mask=0; FSM in IDLE, v=0, counter=0.
- Assertion of `rst_n` low takes effect immediately (asynchronous), including mid-sweep. It aborts the sweep with no `done` pulse.
- `start` is seen at edge S. From after S: a/b=00, busy=1.
- Vector k is sampled at edge S+(k+1)·SETTLE. a/b change to vector k+1 at that same edge.
- Vector 3 is sampled at edge S+4·SETTLE. In the following cycle: done=1, busy=0, and pass/err_count are final.
- After that cycle done=0; the earliest new `start` is accepted at the next edge.
- The outputs of the gate unit must settle within SETTLE cycles; the block adds no input synchronizers.

## Test plan
- Correct gate model, SETTLE=2, start at edge S -> a,b = 00, 01, 10, 11, each held 2 cycles; done pulses in cycle after S+8; pass=1, err_count=0, fail_vec=0, fail_mask=0.
- `x_and` stuck at 0 -> err_count=1, fail_vec=3, fail_mask=7'b0000001, pass=0.
- `x_not` stuck at 1 -> mismatches at v=2 and v=3 -> err_count=2, fail_vec=2, fail_mask=7'b0001000.
- ERRW=4, all seven outputs inverted -> 28 raw mismatches -> err_count saturates at 15; fail_vec=0, fail_mask=7'h7F.
- `start` pulsed mid-RUN and again in the DONE cycle -> both ignored; a/b sequence and the done timing are unchanged; a second sweep is started cleanly after the return to IDLE.
- `rst_n` low during v=1 -> all outputs return to reset values immediately, no done pulse; a new `start` performs a full correct sweep.
